// File: rtl/op_sequencer.sv
// Command issue stage for the matrix controller: buffers command words and
// drives operation/in_data for matmul, serial page write and serial page read.
module op_sequencer #(
  parameter int DEPTH         = 4,
  parameter int PAGE_WORDS    = 64,
  parameter int MATMUL_CYCLES = 520
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic [31:0] operation,
  output logic [31:0] in_data,
  input  logic [31:0] ctl_out_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXC = (MATMUL_CYCLES > PAGE_WORDS) ? MATMUL_CYCLES
                                                     : PAGE_WORDS;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] MM_LAST = CW'(MATMUL_CYCLES - 1);
  localparam logic [CW-1:0] PG_END  = CW'(PAGE_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_MM,
    S_WR,
    S_RD,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   cur_q, cur_d;
  logic [31:0]   op_q, op_d;
  logic [31:0]   in_q, in_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          issue_q, issue_d;

  logic [31:0]   fifo_q [DEPTH];
  logic [31:0]   fifo_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   fcnt_q, fcnt_d;

  logic [31:0]   sk_q [2];
  logic [31:0]   sk_d [2];
  logic          sk_wp_q, sk_wp_d;
  logic          sk_rp_q, sk_rp_d;
  logic [1:0]    sk_cnt_q, sk_cnt_d;

  logic        pop;
  logic        push;
  logic        wr_acc;
  logic        rd_pop;
  logic        cap;
  logic [31:0] head;
  logic [3:0]  opc;

  assign head = fifo_q[rp_q];
  assign opc  = head[3:0];

  assign pop       = enable && (state_q == S_IDLE) && (fcnt_q != '0);
  assign cmd_ready = enable && ((fcnt_q < FULL) || pop);
  assign push      = cmd_valid && cmd_ready;

  assign wr_ready = enable && (state_q == S_WR) && (cnt_q != PG_END);
  assign wr_acc   = wr_ready && wr_valid;

  assign rd_valid = (sk_cnt_q != 2'd0);
  assign rd_data  = sk_q[sk_rp_q];
  assign rd_pop   = enable && rd_valid && rd_ready;
  // A read shown on operation this cycle returns its word this cycle.
  assign cap      = enable && issue_q;

  assign operation = op_q;
  assign in_data   = in_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (fcnt_q != '0) || (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    op_d     = op_q;
    in_d     = in_q;
    done_d   = done_q;
    err_d    = err_q;
    issue_d  = issue_q;
    fifo_d   = fifo_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    sk_d     = sk_q;
    sk_wp_d  = sk_wp_q;
    sk_rp_d  = sk_rp_q;

    if (push) begin
      fifo_d[wp_q] = cmd_data;
      wp_d         = wp_q + AW'(1);
    end
    if (pop) rp_d = rp_q + AW'(1);
    fcnt_d = fcnt_q + (AW+1)'(push) - (AW+1)'(pop);

    if (cap) begin
      sk_d[sk_wp_q] = ctl_out_data;
      sk_wp_d       = ~sk_wp_q;
    end
    if (rd_pop) sk_rp_d = ~sk_rp_q;
    sk_cnt_d = sk_cnt_q + 2'(cap) - 2'(rd_pop);

    if (enable) begin
      done_d  = 1'b0;
      err_d   = 1'b0;
      issue_d = 1'b0;
      op_d    = '0;
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            cur_d = head;
            cnt_d = '0;
            unique case (1'b1)
              (opc == 4'd0): done_d = 1'b1;
              (opc == 4'd1): begin
                state_d = S_MM;
                op_d    = head;
              end
              (opc == 4'd2): state_d = S_WR;
              (opc == 4'd3): state_d = S_RD;
              default:       err_d = 1'b1;
            endcase
          end
        end
        S_MM: begin
          if (cnt_q == MM_LAST) begin
            state_d = S_GAP;
            done_d  = 1'b1;
          end else begin
            op_d  = cur_q;
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WR: begin
          if (cnt_q == PG_END) begin
            state_d = S_GAP;
            done_d  = 1'b1;
          end else if (wr_acc) begin
            op_d  = cur_q;
            in_d  = wr_data;
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RD: begin
          // Issue only if the word it returns next cycle is sure to fit.
          if (cnt_q == PG_END) begin
            state_d = S_DRAIN;
          end else if (sk_cnt_d <= 2'd1) begin
            op_d    = cur_q;
            issue_d = 1'b1;
            cnt_d   = cnt_q + CW'(1);
          end
        end
        S_DRAIN: begin
          if (sk_cnt_q == 2'd0) begin
            state_d = S_GAP;
            done_d  = 1'b1;
          end
        end
        S_GAP: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cur_q    <= '0;
      op_q     <= '0;
      in_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      issue_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      fcnt_q   <= '0;
      sk_q[0]  <= '0;
      sk_q[1]  <= '0;
      sk_wp_q  <= 1'b0;
      sk_rp_q  <= 1'b0;
      sk_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      op_q     <= op_d;
      in_q     <= in_d;
      done_q   <= done_d;
      err_q    <= err_d;
      issue_q  <= issue_d;
      fifo_q   <= fifo_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      fcnt_q   <= fcnt_d;
      sk_q     <= sk_d;
      sk_wp_q  <= sk_wp_d;
      sk_rp_q  <= sk_rp_d;
      sk_cnt_q <= sk_cnt_d;
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: reset, matmul, FIFO limits,
// illegal/idle opcodes, paced writes and back-pressured reads.
module tb_op_sequencer;

  localparam int PW = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_data = '0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_ready = 1'b0;
  logic [31:0] ctl_out_data = '0;
  logic        cmd_ready, wr_ready, rd_valid;
  logic [31:0] rd_data, operation, in_data;
  logic        busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  op_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .operation    (operation),
    .in_data      (in_data),
    .ctl_out_data (ctl_out_data),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] d);
    int k = 0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    while (!cmd_ready && k < 50) begin
      step();
      k++;
    end
    check("push_rdy", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_op(input logic [31:0] v);
    int k = 0;
    while (operation !== v && k < 50) begin
      step();
      k++;
    end
    check("wait_op", operation, v);
  endtask

  task automatic run_len(input logic [31:0] v, output int n, output int dn);
    n  = 0;
    dn = 0;
    while (operation === v && n < 2000) begin
      if (done) dn++;
      n++;
      step();
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dn, er, k, sent, shown, iss, got, maxq, stab, bad_op;
    int err_at, done_at, nz;
    logic prev_acc, hold_v, seen;
    logic [31:0] hold_d;
    logic [31:0] q[$];

    repeat (3) @(posedge clk);
    #2;
    check("rst_op", operation, 32'd0);
    check("rst_in", in_data, 32'd0);
    check("rst_rdd", rd_data, 32'd0);
    check("rst_rdv", 32'(rd_valid), 32'd0);
    check("rst_wrr", 32'(wr_ready), 32'd0);
    check("rst_cmdr", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    step();

    // Asynchronous reset on the 100th matmul cycle
    push(32'h0000_8401);
    wait_op(32'h0000_8401);
    repeat (99) step();
    check("mid_op", operation, 32'h0000_8401);
    reset = 1'b1;
    #1;
    check("arst_op", operation, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cmdr", 32'(cmd_ready), 32'd1);
    dn = 0;
    if (done) dn++;
    repeat (2) begin
      step();
      if (done) dn++;
    end
    reset = 1'b0;
    repeat (5) begin
      step();
      if (done) dn++;
    end
    check("arst_nodone", 32'(dn), 32'd0);
    check("arst_op2", operation, 32'd0);

    // Back-to-back matmul
    cmd_valid = 1'b1;
    cmd_data  = 32'h0000_8401;
    check("b2b_rdy", 32'(cmd_ready), 32'd1);
    step();
    check("lat_t1", operation, 32'd0);
    cmd_data = 32'h0000_9501;
    step();
    cmd_valid = 1'b0;
    check("lat_t2", operation, 32'h0000_8401);
    run_len(32'h0000_8401, n, dn);
    check("mm1_len", 32'(n), 32'd520);
    check("mm1_early", 32'(dn), 32'd0);
    check("gap1_op", operation, 32'd0);
    check("gap1_done", 32'(done), 32'd1);
    step();
    check("idle1_op", operation, 32'd0);
    check("idle1_done", 32'(done), 32'd0);
    step();
    check("mm2_start", operation, 32'h0000_9501);
    run_len(32'h0000_9501, n, dn);
    check("mm2_len", 32'(n), 32'd520);
    check("gap2_done", 32'(done), 32'd1);
    step();
    check("b2b_busy", 32'(busy), 32'd0);

    // FIFO limits during a running matmul, plus enable freeze
    push(32'h0000_0201);
    wait_op(32'h0000_0201);
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = 32'((i + 1) << 4);
      check("fill_rdy", 32'(cmd_ready), 32'd1);
      step();
    end
    cmd_data = 32'h0000_0050;
    check("full_rdy", 32'(cmd_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    repeat (3) step();
    check("en_op", operation, 32'h0000_0201);
    check("en_cmdr", 32'(cmd_ready), 32'd0);
    enable = 1'b1;
    dn = 0;
    er = 0;
    k  = 0;
    while (!cmd_ready && k < 1000) begin
      if (done) dn++;
      step();
      k++;
    end
    check("popfull_rdy", 32'(cmd_ready), 32'd1);
    check("popfull_op", operation, 32'd0);
    if (done) dn++;
    step();
    cmd_valid = 1'b0;
    k = 0;
    while (busy && k < 100) begin
      if (done) dn++;
      if (err) er++;
      step();
      k++;
    end
    if (done) dn++;
    check("fifo_dones", 32'(dn), 32'd6);
    check("fifo_errs", 32'(er), 32'd0);
    check("fifo_idle", 32'(busy), 32'd0);
    step();

    // Illegal then idle opcode
    er = 0;
    dn = 0;
    nz = 0;
    err_at = -1;
    done_at = -1;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = (i < 2);
      cmd_data  = (i == 0) ? 32'h7 : 32'h0;
      if (err) begin
        er++;
        err_at = i;
      end
      if (done) begin
        dn++;
        done_at = i;
      end
      if (operation != 32'd0) nz++;
      step();
    end
    cmd_valid = 1'b0;
    check("ill_err", 32'(er), 32'd1);
    check("ill_done", 32'(dn), 32'd1);
    check("ill_err_at", 32'(err_at), 32'd2);
    check("ill_done_at", 32'(done_at), 32'd3);
    check("ill_op0", 32'(nz), 32'd0);

    // Serial write, wr_valid low every 5th cycle
    push(32'h0000_0002);
    k = 0;
    sent = 0;
    shown = 0;
    prev_acc = 1'b0;
    seen = 1'b0;
    while (k < 400) begin
      if (prev_acc) begin
        check("wr_op", operation, 32'h2);
        check("wr_dat", in_data, 32'(shown));
        shown++;
      end else begin
        check("wr_zero", operation, 32'd0);
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      wr_valid = (k % 5 != 4) && (sent < PW);
      wr_data  = 32'(sent);
      prev_acc = wr_valid && wr_ready;
      if (prev_acc) sent++;
      step();
      k++;
    end
    wr_valid = 1'b0;
    check("wr_shown", 32'(shown), 32'd64);
    check("wr_sent", 32'(sent), 32'd64);
    check("wr_donex", 32'(seen), 32'd1);
    step();

    // Serial read, rd_ready pattern 1,0,0
    push(32'h0000_0043);
    k = 0;
    iss = 0;
    got = 0;
    maxq = 0;
    stab = 0;
    bad_op = 0;
    hold_v = 1'b0;
    hold_d = '0;
    seen = 1'b0;
    while (k < 1000) begin
      rd_ready     = (k % 3 == 0);
      ctl_out_data = 32'(k);
      if (hold_v && (!rd_valid || rd_data !== hold_d)) stab++;
      hold_v = rd_valid && !rd_ready;
      hold_d = rd_data;
      if (rd_valid && rd_ready) begin
        if (q.size() == 0) check("rd_extra", 32'd1, 32'd0);
        else check("rd_dat", rd_data, q.pop_front());
        got++;
      end
      if (operation == 32'h43) begin
        q.push_back(32'(k));
        iss++;
      end else if (operation != 32'd0) begin
        bad_op++;
      end
      if (q.size() > maxq) maxq = q.size();
      if (done) begin
        seen = 1'b1;
        break;
      end
      step();
      k++;
    end
    rd_ready = 1'b0;
    check("rd_issues", 32'(iss), 32'd64);
    check("rd_got", 32'(got), 32'd64);
    check("rd_left", 32'(q.size()), 32'd0);
    check("rd_maxq", 32'(maxq <= 2), 32'd1);
    check("rd_stable", 32'(stab), 32'd0);
    check("rd_badop", 32'(bad_op), 32'd0);
    check("rd_donex", 32'(seen), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
